// File: rtl/key_sw_input_unit.sv
`default_nettype none
// ============================================================================
// Module   : key_sw_input_unit
// Brief    : Memory-mapped KEY/SW input peripheral. It provides sync, debounce,
//            sticky ready/overrun status and a combinational read port.
// Revision : 1.0 - initial release
// ============================================================================
module key_sw_input_unit #(
  parameter int               DBITS           = 32,
  parameter int               DEBOUNCE_CYCLES = 10,
  parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             isLoad,
  input  logic             isStore,
  input  logic [DBITS-1:0] wrData,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [DBITS-1:0] rdData,
  output logic             rdHit,
  output logic             intr
);

  localparam int NB = 14;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NB-1:0] w_raw;
  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;
  logic [NB-1:0] w_stable;
  logic [NB-1:0] w_flip;

  // Keys are inverted on entry so that a stable 1 means "pressed".
  assign w_raw = {SW, ~KEY};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_db
    logic [CW-1:0] r_cnt;
    logic          r_stb;
    logic          w_diff;

    assign w_diff      = r_sync2[i] != r_stb;
    assign w_flip[i]   = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign w_stable[i] = r_stb;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
        r_stb <= 1'b0;
      end else if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_flip[i]) begin
        r_cnt <= '0;
        r_stb <= ~r_stb;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  logic w_k_event, w_s_event;
  logic w_k_store, w_s_store;
  logic w_k_clr_rdy, w_k_clr_ovr, w_s_clr_rdy, w_s_clr_ovr;
  logic r_k_rdy, r_k_ovr, r_s_rdy, r_s_ovr;

  assign w_k_event   = |w_flip[3:0];
  assign w_s_event   = |w_flip[NB-1:4];
  assign w_k_store   = isStore && (addr == ADDR_KCTRL);
  assign w_s_store   = isStore && (addr == ADDR_SCTRL);
  // Writing 0 to a status bit clears it; writing 1 leaves it alone.
  assign w_k_clr_rdy = w_k_store && !wrData[0];
  assign w_k_clr_ovr = w_k_store && !wrData[2];
  assign w_s_clr_rdy = w_s_store && !wrData[0];
  assign w_s_clr_ovr = w_s_store && !wrData[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k_rdy <= 1'b0;
      r_k_ovr <= 1'b0;
      r_s_rdy <= 1'b0;
      r_s_ovr <= 1'b0;
    end else begin
      r_k_rdy <= w_k_event || (r_k_rdy && !w_k_clr_rdy);
      r_k_ovr <= (w_k_event && r_k_rdy && !w_k_clr_rdy) || (r_k_ovr && !w_k_clr_ovr);
      r_s_rdy <= w_s_event || (r_s_rdy && !w_s_clr_rdy);
      r_s_ovr <= (w_s_event && r_s_rdy && !w_s_clr_rdy) || (r_s_ovr && !w_s_clr_ovr);
    end
  end

  logic w_unused;
  assign w_unused = ^{wrData[DBITS-1:3], wrData[1]};

  always_comb begin
    rdHit  = 1'b0;
    rdData = '0;
    if (isLoad) begin
      if (addr == ADDR_KEY) begin
        rdHit  = 1'b1;
        rdData = {{(DBITS-4){1'b0}}, w_stable[3:0]};
      end else if (addr == ADDR_SW) begin
        rdHit  = 1'b1;
        rdData = {{(DBITS-10){1'b0}}, w_stable[NB-1:4]};
      end else if (addr == ADDR_KCTRL) begin
        rdHit  = 1'b1;
        rdData = {{(DBITS-3){1'b0}}, r_k_ovr, 1'b0, r_k_rdy};
      end else if (addr == ADDR_SCTRL) begin
        rdHit  = 1'b1;
        rdData = {{(DBITS-3){1'b0}}, r_s_ovr, 1'b0, r_s_rdy};
      end
    end
  end

  assign intr = r_k_rdy || r_s_rdy;

endmodule
`default_nettype wire

// File: tb/tb_key_sw_input_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_sw_input_unit
// Brief    : Scoreboard bench for key_sw_input_unit register reads and status.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_sw_input_unit;

  localparam logic [31:0] C_KEY   = 32'hF0000010;
  localparam logic [31:0] C_SW    = 32'hF0000014;
  localparam logic [31:0] C_KCTRL = 32'hF0000110;
  localparam logic [31:0] C_SCTRL = 32'hF0000114;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        isLoad;
  logic        isStore;
  logic [31:0] wrData;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [31:0] rdData;
  logic        rdHit;
  logic        intr;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  key_sw_input_unit #(
    .DBITS(32),
    .DEBOUNCE_CYCLES(10)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .isLoad (isLoad),
    .isStore(isStore),
    .wrData (wrData),
    .KEY    (KEY),
    .SW     (SW),
    .rdData (rdData),
    .rdHit  (rdHit),
    .intr   (intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1ns after a rising edge; reads settle within the same cycle.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp,
                    input logic exp_hit);
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    addr   = a;
    isLoad = 1'b1;
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, rdData, e);
    chk({t, "_hit"}, {31'b0, rdHit}, {31'b0, exp_hit});
    isLoad = 1'b0;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    addr    = a;
    wrData  = d;
    isStore = 1'b1;
    tick(1);
    isStore = 1'b0;
    wrData  = '0;
  endtask

  initial begin
    reset = 1'b1; addr = '0; isLoad = 1'b0; isStore = 1'b0; wrData = '0;
    KEY = 4'hF; SW = '0;
    tick(3);
    rd("rst_kdata", C_KEY, 32'h0, 1'b1);
    chk("rst_intr", {31'b0, intr}, 32'h0);
    reset = 1'b0;

    // Idle: nothing must change with keys released and switches low.
    for (int i = 0; i < 5; i++) begin
      tick(10);
      rd("idle_kdata", C_KEY,   32'h0, 1'b1);
      rd("idle_sdata", C_SW,    32'h0, 1'b1);
      rd("idle_kctrl", C_KCTRL, 32'h0, 1'b1);
      rd("idle_sctrl", C_SCTRL, 32'h0, 1'b1);
      chk("idle_intr", {31'b0, intr}, 32'h0);
    end

    // KEY[1] press: stable value appears exactly 12 edges later.
    KEY = 4'hD;
    tick(11);
    rd("k1_early", C_KEY, 32'h0, 1'b1);
    tick(1);
    rd("k1_kdata", C_KEY, 32'h2, 1'b1);
    tick(1);
    rd("k1_kctrl", C_KCTRL, 32'h1, 1'b1);
    chk("k1_intr", {31'b0, intr}, 32'h1);
    st(C_KCTRL, 32'h0);
    rd("k1_clr", C_KCTRL, 32'h0, 1'b1);
    rd("k1_keep", C_KEY, 32'h2, 1'b1);
    chk("k1_intr_clr", {31'b0, intr}, 32'h0);

    // SW[3] bounce shorter than the debounce window is rejected.
    SW = 10'h008;
    tick(5);
    SW = 10'h000;
    tick(15);
    rd("bounce_sdata", C_SW,    32'h0, 1'b1);
    rd("bounce_sctrl", C_SCTRL, 32'h0, 1'b1);
    SW = 10'h008;
    tick(11);
    rd("sw3_early", C_SW, 32'h0, 1'b1);
    tick(1);
    rd("sw3_sdata", C_SW, 32'h8, 1'b1);
    tick(1);
    rd("sw3_sctrl", C_SCTRL, 32'h1, 1'b1);
    chk("sw3_intr", {31'b0, intr}, 32'h1);

    // Release then press again without clearing: overrun.
    KEY = 4'hF;
    tick(14);
    rd("rel_kdata", C_KEY,   32'h0, 1'b1);
    rd("rel_kctrl", C_KCTRL, 32'h1, 1'b1);
    KEY = 4'hD;
    tick(14);
    rd("ovr_kctrl", C_KCTRL, 32'h5, 1'b1);
    st(C_KCTRL, 32'h1);
    rd("ovr_clr", C_KCTRL, 32'h1, 1'b1);
    // Release event lands on the same edge as a clear-all store.
    KEY = 4'hF;
    tick(11);
    st(C_KCTRL, 32'h0);
    rd("coinc_kctrl", C_KCTRL, 32'h1, 1'b1);
    rd("coinc_kdata", C_KEY,   32'h0, 1'b1);

    // Reset partway through a KEY[0] debounce.
    KEY = 4'hE;
    tick(6);
    reset = 1'b1;
    tick(2);
    rd("mid_kdata", C_KEY,   32'h0, 1'b1);
    rd("mid_sdata", C_SW,    32'h0, 1'b1);
    rd("mid_kctrl", C_KCTRL, 32'h0, 1'b1);
    rd("mid_sctrl", C_SCTRL, 32'h0, 1'b1);
    chk("mid_intr", {31'b0, intr}, 32'h0);
    reset = 1'b0;
    tick(11);
    rd("post_early", C_KEY, 32'h0, 1'b1);
    tick(1);
    rd("post_kdata", C_KEY, 32'h1, 1'b1);
    rd("post_sdata", C_SW,  32'h8, 1'b1);
    tick(1);
    rd("post_kctrl", C_KCTRL, 32'h1, 1'b1);
    rd("post_sctrl", C_SCTRL, 32'h1, 1'b1);

    // Address decode and ignored stores.
    rd("miss_addr", 32'hF0000018, 32'h0, 1'b0);
    addr = C_KEY;
    #1;
    chk("noload_data", rdData, 32'h0);
    chk("noload_hit", {31'b0, rdHit}, 32'h0);
    st(C_KEY, 32'h0);
    rd("stkey_kctrl", C_KCTRL, 32'h1, 1'b1);
    rd("stkey_kdata", C_KEY,   32'h1, 1'b1);
    st(C_SCTRL, 32'h0);
    rd("sclr_sctrl", C_SCTRL, 32'h0, 1'b1);
    rd("sclr_kctrl", C_KCTRL, 32'h1, 1'b1);
    chk("sclr_intr", {31'b0, intr}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
